// File: rtl/adat_tx_param.sv
// ADAT lightpipe transmitter with one-frame holding buffer.
// Serialises 256-bit NRZ frames as NRZI, one bit per bit_en strobe.
module adat_tx_param #(
  parameter int SAMPLE_WIDTH  = 24,
  parameter int NUM_CHANNELS  = 8,
  parameter int UNDERRUN_MODE = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 bit_en,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] in_data,
  input  logic [2:0]                           user_bits,
  input  logic [NUM_CHANNELS-1:0]              mute,
  output logic                                 adat_out,
  output logic                                 frame_start,
  output logic                                 underrun,
  output logic [15:0]                          underrun_count
);

  localparam int PW = NUM_CHANNELS * SAMPLE_WIDTH;

  logic [PW-1:0]  buf_q;
  logic [PW-1:0]  last_q;
  logic [PW-1:0]  audio;
  logic           buf_full;
  logic [7:0]     bit_cnt;
  logic [255:0]   sr_q;
  logic [255:0]   frame;
  logic [23:0]    slot [8];
  logic           load;
  logic           accept;

  assign load     = bit_en && (bit_cnt == 8'd255);
  assign accept   = in_valid && !buf_full;
  assign in_ready = !buf_full;

  // Underrun payload: silence, or replay of the last sent pre-mute audio
  assign audio = buf_full ? buf_q :
                 ((UNDERRUN_MODE != 0) ? last_q : '0);

  for (genvar c = 0; c < 8; c++) begin : g_slot
    if (c < NUM_CHANNELS) begin : g_act
      logic [23:0] s;
      always_comb begin
        s = '0;
        s[23 -: SAMPLE_WIDTH] = audio[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
      assign slot[c] = mute[c] ? 24'd0 : s;
    end else begin : g_off
      assign slot[c] = 24'd0;
    end
  end

  assign frame[15:0] = {1'b0, user_bits, 12'h801};

  for (genvar c = 0; c < 8; c++) begin : g_ch
    for (genvar s = 0; s < 6; s++) begin : g_nib
      localparam int B = 16 + (c*6 + s)*5;
      assign frame[B] = 1'b1;
      for (genvar k = 0; k < 4; k++) begin : g_bit
        assign frame[B+1+k] = slot[c][23-4*s-k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      last_q   <= '0;
    end else begin
      if (accept) begin
        buf_q    <= in_data;
        buf_full <= 1'b1;
      end else if (load && buf_full) begin
        buf_full <= 1'b0;
        last_q   <= buf_q;
      end
    end
  end

  // Bit 0 of a new frame goes straight to the line on the load edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt        <= 8'hFF;
      sr_q           <= '0;
      adat_out       <= 1'b0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      frame_start <= load;
      underrun    <= load && !buf_full;
      if (load) begin
        bit_cnt  <= 8'd0;
        sr_q     <= {1'b0, frame[255:1]};
        adat_out <= adat_out ^ frame[0];
        if (!buf_full && underrun_count != 16'hFFFF)
          underrun_count <= underrun_count + 16'd1;
      end else if (bit_en) begin
        bit_cnt  <= bit_cnt + 8'd1;
        sr_q     <= {1'b0, sr_q[255:1]};
        adat_out <= adat_out ^ sr_q[0];
      end
    end
  end

endmodule

// File: tb/tb_adat_tx_param.sv
// Directed bench for adat_tx_param: NRZI decode of the line,
// frame layout, handshake, underrun, bit_en gating and reset.
module tb_adat_tx_param;

  typedef struct {
    logic [191:0]     data;
    logic [2:0]       ub;
    logic [7:0]       mute;
    logic [15:0]      hdr;
    logic [7:0][23:0] sl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         bit_en_a, valid_a, ready_a, adat_a, fs_a, ur_a;
  logic [191:0] data_a;
  logic [2:0]   ub_a;
  logic [7:0]   mute_a;
  logic [15:0]  cnt_a;

  logic         bit_en_b, valid_b, ready_b, adat_b, fs_b, ur_b;
  logic [31:0]  data_b;
  logic [2:0]   ub_b;
  logic [1:0]   mute_b;
  logic [15:0]  cnt_b;

  adat_tx_param dut_a (
    .clk(clk), .rst(rst), .bit_en(bit_en_a),
    .in_valid(valid_a), .in_ready(ready_a), .in_data(data_a),
    .user_bits(ub_a), .mute(mute_a), .adat_out(adat_a),
    .frame_start(fs_a), .underrun(ur_a), .underrun_count(cnt_a)
  );

  adat_tx_param #(
    .SAMPLE_WIDTH(16), .NUM_CHANNELS(2), .UNDERRUN_MODE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bit_en(bit_en_b),
    .in_valid(valid_b), .in_ready(ready_b), .in_data(data_b),
    .user_bits(ub_b), .mute(mute_b), .adat_out(adat_b),
    .frame_start(fs_b), .underrun(ur_b), .underrun_count(cnt_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_div = 1;
  int ph = 0;
  bit chk_chg = 1'b0;
  int chg_err = 0;
  int idx_a = -1;
  int idx_b = -1;
  logic [255:0] acc_a, acc_b;
  logic [255:0] frames_a[$];
  logic [255:0] frames_b[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (a_div == 0) bit_en_a = 1'b0;
    else begin
      bit_en_a = (ph == 0);
      ph = (ph + 1) % a_div;
    end
  end

  always @(posedge clk) begin : mon_a
    logic en, pv;
    en = bit_en_a;
    pv = adat_a;
    #1;
    if (chk_chg && !en && adat_a !== pv) chg_err++;
    if (en) begin
      if (fs_a) idx_a = 0;
      if (idx_a >= 0) begin
        acc_a[idx_a] = adat_a ^ pv;
        idx_a++;
        if (idx_a == 256) begin
          frames_a.push_back(acc_a);
          idx_a = -1;
        end
      end
    end
  end

  always @(posedge clk) begin : mon_b
    logic en, pv;
    en = bit_en_b;
    pv = adat_b;
    #1;
    if (en) begin
      if (fs_b) idx_b = 0;
      if (idx_b >= 0) begin
        acc_b[idx_b] = adat_b ^ pv;
        idx_b++;
        if (idx_b == 256) begin
          frames_b.push_back(acc_b);
          idx_b = -1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] get_slot(input logic [255:0] f,
                                           input int c);
    logic [23:0] r;
    r = '0;
    for (int s = 0; s < 6; s++)
      for (int k = 0; k < 4; k++)
        r[23-4*s-k] = f[16+(c*6+s)*5+1+k];
    return r;
  endfunction

  function automatic logic [47:0] get_sync(input logic [255:0] f);
    logic [47:0] r;
    for (int j = 0; j < 48; j++) r[j] = f[16+5*j];
    return r;
  endfunction

  task automatic chk_frame(input string tag, input logic [255:0] f,
                           input logic [15:0] hdr,
                           input logic [7:0][23:0] sl);
    chk({tag, "_hdr"}, 256'(f[15:0]), 256'(hdr));
    chk({tag, "_sync"}, 256'(get_sync(f)), 256'({48{1'b1}}));
    for (int c = 0; c < 8; c++)
      chk($sformatf("%s_ch%0d", tag, c),
          256'(get_slot(f, c)), 256'(sl[c]));
  endtask

  task automatic wait_fs(input bit b, input int lim, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(b ? fs_b : fs_a) && n < lim);
    chk(name, 256'(b ? fs_b : fs_a), 256'(1));
  endtask

  task automatic wait_frames(input bit b, input int want, input string name);
    int n;
    n = 0;
    while ((b ? frames_b.size() : frames_a.size()) < want && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 256'(b ? frames_b.size() : frames_a.size()), 256'(want));
  endtask

  vec_t             vt [4];
  logic [7:0][23:0] sz, sb, sd;
  int               t_prev, t1, nfr;

  initial begin
    vt[0].data = 192'h800001;
    vt[0].ub   = 3'b001;
    vt[0].mute = 8'h00;
    vt[0].hdr  = 16'h1801;
    vt[0].sl   = 192'h800001;
    vt[1].data = {24'hBCDEF0, 24'h56789A, 24'hF01234, 24'h9ABCDE,
                  24'h345678, 24'hDEF012, 24'h789ABC, 24'h123456};
    vt[1].ub   = 3'b110;
    vt[1].mute = 8'h00;
    vt[1].hdr  = 16'h6801;
    vt[1].sl   = vt[1].data;
    vt[2].data = vt[1].data;
    vt[2].ub   = 3'b010;
    vt[2].mute = 8'hA5;
    vt[2].hdr  = 16'h2801;
    vt[2].sl   = {24'h0, 24'h56789A, 24'h0, 24'h9ABCDE,
                  24'h345678, 24'h0, 24'h789ABC, 24'h0};
    vt[3].data = {24'hFFFFFF, 24'h0, 24'h0, 24'h0,
                  24'h800000, 24'h0, 24'h0, 24'h0};
    vt[3].ub   = 3'b100;
    vt[3].mute = 8'h00;
    vt[3].hdr  = 16'h4801;
    vt[3].sl   = vt[3].data;
    sz = '0;

    valid_a = 1'b0; data_a = '0; ub_a = '0; mute_a = '0;
    bit_en_b = 1'b0; valid_b = 1'b0; data_b = '0;
    ub_b = '0; mute_b = '0;

    #1;
    chk("rst_adat", 256'(adat_a), 256'(0));
    chk("rst_fs", 256'(fs_a), 256'(0));
    chk("rst_ur", 256'(ur_a), 256'(0));
    chk("rst_cnt", 256'(cnt_a), 256'(0));
    chk("rst_ready", 256'(ready_a), 256'(1));
    chk("rst_ready_b", 256'(ready_b), 256'(1));

    // Default config: four frames back to back, in_valid kept high
    repeat (3) @(negedge clk);
    data_a = vt[0].data; ub_a = vt[0].ub; mute_a = vt[0].mute;
    valid_a = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("exit_fs", 256'(fs_a), 256'(1));
    chk("exit_ur", 256'(ur_a), 256'(1));
    chk("exit_acc", 256'(ready_a), 256'(0));
    t_prev = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_fs(1'b0, 300, $sformatf("v%0d_load", i));
      chk($sformatf("v%0d_period", i), 256'(cyc - t_prev), 256'(256));
      t_prev = cyc;
      chk($sformatf("v%0d_ur", i), 256'(ur_a), 256'(0));
      chk($sformatf("v%0d_ready", i), 256'(ready_a), 256'(1));
      if (i < 3) begin
        data_a = vt[i+1].data; ub_a = vt[i+1].ub; mute_a = vt[i+1].mute;
        @(posedge clk); #1;
        chk($sformatf("v%0d_acc", i+1), 256'(ready_a), 256'(0));
      end else begin
        valid_a = 1'b0; ub_a = '0; mute_a = '0;
      end
    end
    wait_fs(1'b0, 300, "a_ur_load");
    chk("a_ur_pulse", 256'(ur_a), 256'(1));
    chk("a_ur_cnt", 256'(cnt_a), 256'(2));
    wait_frames(1'b0, 6, "a_frames");
    if (frames_a.size() >= 6) begin
      chk_frame("a_f0", frames_a[0], 16'h1801, sz);
      for (int i = 0; i < 4; i++)
        chk_frame($sformatf("a_v%0d", i), frames_a[i+1], vt[i].hdr, vt[i].sl);
      chk_frame("a_ur", frames_a[5], 16'h0801, sz);
    end

    // 16-bit, 2-channel, repeat-on-underrun instance
    @(negedge clk);
    data_b = {16'h1234, 16'hABCD}; ub_b = 3'b101; mute_b = 2'b00;
    valid_b = 1'b1;
    @(posedge clk); #1;
    chk("b_acc_noen", 256'(ready_b), 256'(0));
    chk("b_frozen", 256'(fs_b), 256'(0));
    @(negedge clk);
    valid_b = 1'b0;
    bit_en_b = 1'b1;
    @(posedge clk); #1;
    chk("b_load_fs", 256'(fs_b), 256'(1));
    chk("b_load_ur", 256'(ur_b), 256'(0));
    chk("b_load_ready", 256'(ready_b), 256'(1));
    wait_fs(1'b1, 300, "b_rep_load");
    chk("b_rep_ur", 256'(ur_b), 256'(1));
    chk("b_rep_cnt", 256'(cnt_b), 256'(1));
    mute_b = 2'b01;
    wait_fs(1'b1, 300, "b_mute_load");
    chk("b_mute_cnt", 256'(cnt_b), 256'(2));
    wait_frames(1'b1, 3, "b_frames");
    bit_en_b = 1'b0;
    sb = '0; sb[0] = 24'hABCD00; sb[1] = 24'h123400;
    if (frames_b.size() >= 3) begin
      chk_frame("b_f0", frames_b[0], 16'h5801, sb);
      chk("b_repeat", frames_b[1], frames_b[0]);
      sb[0] = 24'h0;
      chk_frame("b_f2", frames_b[2], 16'h5801, sb);
    end

    // bit_en one clk in four, channel 2 muted
    @(negedge clk);
    a_div = 4;
    data_a = '0;
    data_a[71:48] = 24'h7FFFFF;
    data_a[23:0]  = 24'h000010;
    mute_a = 8'h04; ub_a = 3'b000;
    valid_a = 1'b1;
    chg_err = 0;
    chk_chg = 1'b1;
    @(posedge clk); #1;
    chk("div_acc", 256'(ready_a), 256'(0));
    valid_a = 1'b0;
    wait_fs(1'b0, 1100, "div_load");
    t1 = cyc;
    nfr = frames_a.size();
    wait_fs(1'b0, 1100, "div_next");
    chk("div_period", 256'(cyc - t1), 256'(1024));
    chk("div_nframes", 256'(frames_a.size()), 256'(nfr + 1));
    chk_chg = 1'b0;
    chk("div_chg", 256'(chg_err), 256'(0));
    sd = '0; sd[0] = 24'h000010;
    if (frames_a.size() > nfr)
      chk_frame("div", frames_a[nfr], 16'h0801, sd);

    // Reset roughly 100 bits into a frame with a full buffer
    @(negedge clk);
    a_div = 1;
    wait_fs(1'b0, 1100, "rstm_sync");
    valid_a = 1'b1;
    data_a = vt[1].data;
    @(posedge clk); #1;
    chk("rstm_full", 256'(ready_a), 256'(0));
    valid_a = 1'b0;
    repeat (98) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rstm_adat", 256'(adat_a), 256'(0));
    chk("rstm_ready", 256'(ready_a), 256'(1));
    chk("rstm_cnt", 256'(cnt_a), 256'(0));
    chk("rstm_cnt_b", 256'(cnt_b), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstx_fs", 256'(fs_a), 256'(1));
    chk("rstx_adat", 256'(adat_a), 256'(1));
    chk("rstx_ur", 256'(ur_a), 256'(1));
    chk("rstx_cnt", 256'(cnt_a), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
